// File: rtl/hdb3_dec_mon.sv
// hdb3_dec_mon: HDB3/AMI bipolar line decoder with code-violation, excess-zeros and LOS monitoring.
// Optional saturating error counter enabled by defining HDB3_DEC_MON_ERRCNT_EN.
module hdb3_dec_mon #(
    parameter int LOS_ZEROS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_pos,
    input  logic             in_neg,
    input  logic             in_valid,
    output logic             out_data,
    output logic             out_valid,
    output logic             out_cv,
    output logic             out_exz,
    output logic             los,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [7:0] LZ = 8'(LOS_ZEROS);
    logic [3:0] sr;
    logic       pstate, vpol, vseen;
    logic [7:0] zcnt;
    logic       pulse, viol, cv_n, exz_n;
    assign pulse = in_pos ^ in_neg;
    assign viol  = pulse & ((in_pos & pstate) | (in_neg & ~pstate));
    assign cv_n  = in_valid & ((in_pos & in_neg) |
                   (viol & (mode | (zcnt < 8'd2) | (vseen & (vpol == in_pos)))));
    assign exz_n = in_valid & ~pulse & ~mode & (zcnt == 8'd3);
    // out_data takes the MSB before the update, so a bit leaves four symbols after entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_cv    <= 1'b0;
            out_exz   <= 1'b0;
            los       <= 1'b0;
            sr        <= 4'b0;
            pstate    <= 1'b0;
            vpol      <= 1'b0;
            vseen     <= 1'b0;
            zcnt      <= 8'd0;
        end else begin
            out_valid <= in_valid;
            out_cv    <= cv_n;
            out_exz   <= exz_n;
            if (in_valid) begin
                out_data <= sr[3];
                if (!pulse) begin
                    sr   <= {sr[2:0], 1'b0};
                    zcnt <= (zcnt == LZ) ? zcnt : zcnt + 8'd1;
                    if (zcnt == LZ - 8'd1) los <= 1'b1;
                end else begin
                    zcnt <= 8'd0;
                    los  <= 1'b0;
                    if (!viol) begin
                        sr     <= {sr[2:0], 1'b1};
                        pstate <= ~pstate;
                    end else if (mode) begin
                        sr <= {sr[2:0], 1'b1};
                    end else begin
                        // B00V / 000V: the violation and the three symbols before it decode as zeros
                        sr    <= 4'b0;
                        vpol  <= in_pos;
                        vseen <= 1'b1;
                    end
                end
            end
        end
    end
`ifdef HDB3_DEC_MON_ERRCNT_EN
    logic err;
    assign err = cv_n | exz_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt <= '0;
        else if (err_clr) err_cnt <= CNT_W'(err);
        else if (err && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_hdb3_dec_mon.sv
// tb_hdb3_dec_mon: randomized and directed checks of hdb3_dec_mon against a queue-based decode model.
module tb_hdb3_dec_mon;
    localparam int LOS = 8;
    logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0;
    logic in_pos = 1'b0, in_neg = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
    logic out_data, out_valid, out_cv, out_exz, los;
    logic [1:0] err_cnt;
    logic [6:0] obs, exp_vec;
    int n_checks = 0, n_fail = 0;
    bit dq[$];
    int zr;
    bit last_pol, vpol, vseen;
    logic edata, ecv, eexz, elos;
    logic [1:0] ecnt;

    hdb3_dec_mon #(.LOS_ZEROS(LOS), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_pos(in_pos), .in_neg(in_neg),
        .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid), .out_cv(out_cv),
        .out_exz(out_exz), .los(los), .err_clr(err_clr), .err_cnt(err_cnt));

    always #5 clk = ~clk;
    assign obs = {out_valid, out_data, out_cv, out_exz, los, err_cnt};

    task automatic model_reset();
        dq.delete();
        zr = 0; last_pol = 0; vpol = 0; vseen = 0;
        edata = 0; ecv = 0; eexz = 0; elos = 0; ecnt = 0;
        exp_vec = '0;
    endtask

    task automatic model_sym(input logic p, input logic n, input logic v, input logic c);
        bit err;
        ecv = 0; eexz = 0;
        if (v) begin
            if (p == n) begin
                ecv = p;
                if (!mode && zr == 3) eexz = 1;
                if (zr < 1000) zr++;
                elos = (zr >= LOS);
                dq.push_back(0);
            end else if (p == last_pol) begin
                if (mode) begin
                    ecv = 1;
                    dq.push_back(1);
                end else begin
                    ecv = (zr < 2) || (vseen && p == vpol);
                    for (int k = 1; k <= 3; k++) if (dq.size() >= k) dq[dq.size() - k] = 0;
                    dq.push_back(0);
                    vpol = p; vseen = 1;
                end
                zr = 0; elos = 0;
            end else begin
                last_pol = p;
                dq.push_back(1);
                zr = 0; elos = 0;
            end
            edata = (dq.size() >= 5) ? dq[dq.size() - 5] : 1'b0;
            if (dq.size() > 8) void'(dq.pop_front());
        end
        err = ecv | eexz;
`ifdef HDB3_DEC_MON_ERRCNT_EN
        if (c) ecnt = {1'b0, err};
        else if (err && ecnt != 2'b11) ecnt++;
`endif
        exp_vec = {v, edata, ecv, eexz, elos, ecnt};
    endtask

    task automatic sym(input logic p, input logic n, input logic v, input logic c);
        @(negedge clk);
        in_pos = p; in_neg = n; in_valid = v; err_clr = c;
        model_sym(p, n, v, c);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 7'd0) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs, 7'd0); end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sym(0, 0, 0, 0);
            n_checks++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_idle %0d: got %b want %b", i, obs, exp_vec); end
        end
    endtask

    task automatic test_b00v();
        logic [1:0] s [13] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00,
                               2'b10, 2'b01, 2'b10, 2'b01};
        logic [8:0] dec = '0;
        for (int i = 0; i < 13; i++) begin
            sym(s[i][1], s[i][0], 1, 0);
            if (i >= 4) dec = {dec[7:0], out_data};
            n_checks++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL b00v %0d: got %b want %b", i, obs, exp_vec); end
        end
        n_checks++;
        if (dec !== 9'b100001000) begin n_fail++; $display("FAIL b00v_seq: got %b want %b", dec, 9'b100001000); end
    endtask

    task automatic test_violations();
        logic [1:0] s [16] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01,
                               2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 16; i++) begin
            sym(s[i][1], s[i][0], 1, 0);
            n_checks++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL viol %0d: got %b want %b", i, obs, exp_vec); end
        end
    endtask

    task automatic test_exz();
        for (int m = 0; m < 2; m++) begin
            mode = m[0];
            sym(last_pol ? 1'b0 : 1'b1, last_pol ? 1'b1 : 1'b0, 1, 0);
            for (int i = 0; i < 5; i++) begin
                sym(0, 0, 1, 0);
                n_checks++;
                if (out_exz !== (m == 0 && i == 3)) begin
                    n_fail++; $display("FAIL exz m%0d z%0d: got %b want %b", m, i, out_exz, (m == 0 && i == 3));
                end
                n_checks++;
                if (obs !== exp_vec) begin n_fail++; $display("FAIL exz_vec m%0d z%0d: got %b want %b", m, i, obs, exp_vec); end
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_los();
        sym(1, 0, 1, 0);
        sym(0, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            sym(0, 0, 1, 0);
            n_checks++;
            if (los !== (i == 7)) begin n_fail++; $display("FAIL los_rise z%0d: got %b want %b", i, los, (i == 7)); end
            sym(0, 0, 0, 0);
            n_checks++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL los_gap z%0d: got %b want %b", i, obs, exp_vec); end
        end
        sym(1, 0, 1, 0);
        n_checks++;
        if (los !== 1'b0 || obs !== exp_vec) begin n_fail++; $display("FAIL los_fall: got %b want %b", obs, exp_vec); end
    endtask

    task automatic test_errcnt();
        for (int i = 0; i < 7; i++) begin
            sym(1, 1, 1, i == 6);
            n_checks++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL errcnt %0d: got %b want %b", i, obs, exp_vec); end
        end
        n_checks++;
`ifdef HDB3_DEC_MON_ERRCNT_EN
        if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL errcnt_clr: got %0d want 1", err_cnt); end
`else
        if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL errcnt_off: got %0d want 0", err_cnt); end
`endif
        sym(1, 0, 1, 0);
        sym(0, 1, 1, 1);
        n_checks++;
        if (obs !== exp_vec) begin n_fail++; $display("FAIL errcnt_clr0: got %b want %b", obs, exp_vec); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 19);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            sym(r inside {[10:14], 19}, r inside {[15:19]}, $urandom_range(0, 5) != 0, $urandom_range(0, 29) == 0);
            n_checks++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL random %0d: got %b want %b", i, obs, exp_vec); end
        end
        mode = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) sym($urandom_range(0, 1), 0, 1, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'd0) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, 7'd0); end
        model_reset();
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        test_b00v();
    endtask

    initial begin
        test_reset();
        test_b00v();
        test_violations();
        test_exz();
        test_los();
        test_errcnt();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
